// File: rtl/ad9826_pkg.sv
// Shared definitions for the AD9826 register sequencer: config-word field
// positions, register address names and sequencer state encoding.
package ad9826_pkg;

    localparam int unsigned RW_BIT   = 15;
    localparam int unsigned ADDR_MSB = 14;
    localparam int unsigned ADDR_LSB = 12;
    localparam int unsigned DATA_MSB = 8;
    localparam int unsigned DATA_LSB = 0;

    localparam logic [2:0] CONFIG = 3'd0;
    localparam logic [2:0] MUX    = 3'd1;
    localparam logic [2:0] PGA_R  = 3'd2;
    localparam logic [2:0] PGA_G  = 3'd3;
    localparam logic [2:0] PGA_B  = 3'd4;
    localparam logic [2:0] OFFS_R = 3'd5;
    localparam logic [2:0] OFFS_G = 3'd6;
    localparam logic [2:0] OFFS_B = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_WAIT,
        RD_REQ,
        RD_WAIT,
        CHECK,
        FIN
    } seq_state_t;

    function automatic logic [15:0] make_cfg_word(input logic       rd,
                                                  input logic [2:0] addr,
                                                  input logic [8:0] data);
        logic [15:0] w;
        w = '0;
        w[RW_BIT]            = rd;
        w[ADDR_MSB:ADDR_LSB] = addr;
        w[DATA_MSB:DATA_LSB] = data;
        return w;
    endfunction

endpackage

// File: rtl/ad9826_reg_sequencer_if.sv
// Request/acknowledge bus between the register sequencer and the serial config stage.
interface ad9826_reg_sequencer_if;
    logic [15:0] cfg_word;
    logic        cfg_req;
    logic        cfg_ack;
    logic [8:0]  cfg_rdata;

    modport master (output cfg_word, output cfg_req, input cfg_ack, input cfg_rdata);
    modport slave  (input cfg_word, input cfg_req, output cfg_ack, output cfg_rdata);
endinterface

// File: rtl/ad9826_shadow_regs.sv
// 8 x 9-bit shadow copy of the AD9826 register map: one write port,
// independent combinational read ports for the host and the sequencer.
module ad9826_shadow_regs (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [2:0] waddr,
    input  logic [8:0] wdata,
    input  logic [2:0] host_raddr,
    output logic [8:0] host_rdata,
    input  logic [2:0] seq_raddr,
    output logic [8:0] seq_rdata
);
    logic [8:0] mem_q [8];
    logic [8:0] mem_d [8];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign host_rdata = mem_q[host_raddr];
    assign seq_rdata  = mem_q[seq_raddr];
endmodule

// File: rtl/ad9826_reg_sequencer.sv
// Writes the eight shadow registers to the AD9826 serial config stage in
// address order on apply, optionally reading each back and comparing.
module ad9826_reg_sequencer
    import ad9826_pkg::*;
#(
    parameter bit          VERIFY      = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned TO_W        = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   host_we,
    input  logic [2:0]             host_addr,
    input  logic [8:0]             host_wdata,
    output logic [8:0]             host_rdata,
    input  logic                   apply,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [2:0]             err_addr,
    output logic                   err_timeout,
    ad9826_reg_sequencer_if.master cfg
);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    seq_state_t      state_q, state_d;
    logic [2:0]      addr_q, addr_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [15:0]     cfg_word_q, cfg_word_d;
    logic [8:0]      rdata_q, rdata_d;
    logic            error_q, error_d;
    logic [2:0]      err_addr_q, err_addr_d;
    logic            err_timeout_q, err_timeout_d;
    logic [8:0]      seq_rdata;

    ad9826_shadow_regs u_shadow (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (host_we),
        .waddr      (host_addr),
        .wdata      (host_wdata),
        .host_raddr (host_addr),
        .host_rdata (host_rdata),
        .seq_raddr  (addr_q),
        .seq_rdata  (seq_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            to_cnt_q      <= '0;
            cfg_word_q    <= '0;
            rdata_q       <= '0;
            error_q       <= 1'b0;
            err_addr_q    <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            to_cnt_q      <= to_cnt_d;
            cfg_word_q    <= cfg_word_d;
            rdata_q       <= rdata_d;
            error_q       <= error_d;
            err_addr_q    <= err_addr_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        to_cnt_d      = to_cnt_q;
        cfg_word_d    = cfg_word_q;
        rdata_d       = rdata_q;
        error_d       = error_q;
        err_addr_d    = err_addr_q;
        err_timeout_d = err_timeout_q;
        unique case (state_q)
            IDLE: begin
                if (apply) begin
                    error_d       = 1'b0;
                    err_addr_d    = '0;
                    err_timeout_d = 1'b0;
                    addr_d        = '0;
                    state_d       = WR_REQ;
                end
            end
            WR_REQ: begin
                cfg_word_d = make_cfg_word(1'b0, addr_q, seq_rdata);
                to_cnt_d   = '0;
                state_d    = WR_WAIT;
            end
            WR_WAIT, RD_WAIT: begin
                // ack takes priority over a timeout expiring in the same cycle
                if (cfg.cfg_ack) begin
                    if (state_q == RD_WAIT) begin
                        rdata_d = cfg.cfg_rdata;
                        state_d = CHECK;
                    end else if (addr_q == OFFS_B) begin
                        addr_d  = '0;
                        state_d = VERIFY ? RD_REQ : FIN;
                    end else begin
                        addr_d  = addr_q + 3'd1;
                        state_d = WR_REQ;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    error_d = 1'b1;
                    if (!error_q) begin
                        err_timeout_d = 1'b1;
                        err_addr_d    = addr_q;
                    end
                    state_d = FIN;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            RD_REQ: begin
                cfg_word_d = make_cfg_word(1'b1, addr_q, '0);
                to_cnt_d   = '0;
                state_d    = RD_WAIT;
            end
            CHECK: begin
                if ((rdata_q != seq_rdata) && !error_q) begin
                    error_d    = 1'b1;
                    err_addr_d = addr_q;
                end
                if (addr_q == OFFS_B) begin
                    state_d = FIN;
                end else begin
                    addr_d  = addr_q + 3'd1;
                    state_d = RD_REQ;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE) && (state_q != FIN);
        done        = (state_q == FIN);
        cfg.cfg_req = (state_q == WR_WAIT) || (state_q == RD_WAIT);
    end

    assign cfg.cfg_word = cfg_word_q;
    assign error        = error_q;
    assign err_addr     = err_addr_q;
    assign err_timeout  = err_timeout_q;
endmodule

// File: tb/tb_ad9826_reg_sequencer.sv
// Self-checking bench: two sequencer instances (write-only and verifying) driven
// by a responder that models the serial stage, checked against a shadow model.
module tb_ad9826_reg_sequencer;
    localparam int TO_NV = 4096;

    logic clk = 1'b0;
    logic rst_n;
    logic host_we;
    logic [2:0] host_addr;
    logic [8:0] host_wdata;
    logic apply_n, apply_v;
    logic sel, ack;
    logic [8:0] rdata;

    logic [8:0] hr_n, hr_v;
    logic busy_n, busy_v, done_n, done_v, err_n, err_v, errto_n, errto_v;
    logic [2:0] erra_n, erra_v;

    logic req_s, done_s, busy_s, err_s, errto_s;
    logic [2:0] erra_s;
    logic [15:0] word_s;

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0]  mshadow [8];
    logic [15:0] logw [32];
    logic [15:0] expw [32];

    ad9826_reg_sequencer_if ifn ();
    ad9826_reg_sequencer_if ifv ();

    always #5 clk = ~clk;

    ad9826_reg_sequencer #(.VERIFY(1'b0), .TIMEOUT_CYC(TO_NV), .TO_W(12)) u_nv (
        .clk(clk), .rst_n(rst_n), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(hr_n), .apply(apply_n), .busy(busy_n),
        .done(done_n), .error(err_n), .err_addr(erra_n), .err_timeout(errto_n), .cfg(ifn.master)
    );

    ad9826_reg_sequencer #(.VERIFY(1'b1), .TIMEOUT_CYC(100), .TO_W(7)) u_v (
        .clk(clk), .rst_n(rst_n), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(hr_v), .apply(apply_v), .busy(busy_v),
        .done(done_v), .error(err_v), .err_addr(erra_v), .err_timeout(errto_v), .cfg(ifv.master)
    );

    assign ifn.cfg_ack   = ~sel & ack;
    assign ifv.cfg_ack   = sel & ack;
    assign ifn.cfg_rdata = rdata;
    assign ifv.cfg_rdata = rdata;

    assign req_s   = sel ? ifv.cfg_req  : ifn.cfg_req;
    assign word_s  = sel ? ifv.cfg_word : ifn.cfg_word;
    assign done_s  = sel ? done_v  : done_n;
    assign busy_s  = sel ? busy_v  : busy_n;
    assign err_s   = sel ? err_v   : err_n;
    assign erra_s  = sel ? erra_v  : erra_n;
    assign errto_s = sel ? errto_v : errto_n;

    task automatic host_write(input logic [2:0] a, input logic [8:0] d);
        @(posedge clk); #1;
        host_we = 1'b1; host_addr = a; host_wdata = d;
        mshadow[a] = d;
        @(posedge clk); #1;
        host_we = 1'b0;
    endtask

    // Serial-stage responder: logs each request, acks after a random latency,
    // echoes model shadow on reads (or bad_val for bad_addr), never acks no_ack_pos.
    task automatic run_seq(input int min_lat, input int max_lat, input int no_ack_pos,
                           input int bad_addr, input logic [8:0] bad_val,
                           input int inj_pos, input logic [2:0] inj_a, input logic [8:0] inj_d,
                           output int n_words, output int n_done, output int done_cyc,
                           output int to_cycles, output int late_reqs);
        int cyc, cnt, to_start;
        bit pending;
        logic [2:0] a;
        n_words = 0; n_done = 0; done_cyc = -1; to_cycles = -1; late_reqs = 0;
        cyc = 0; cnt = 0; to_start = 0; pending = 1'b0;
        @(posedge clk); #1;
        if (sel) apply_v = 1'b1; else apply_n = 1'b1;
        while (cyc < 6000 && (done_cyc < 0 || cyc < done_cyc + 10)) begin
            @(posedge clk); #1;
            cyc++;
            apply_v = 1'b0; apply_n = 1'b0; host_we = 1'b0; ack = 1'b0;
            if (done_s) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    if (pending && no_ack_pos == n_words - 1) to_cycles = cyc - to_start;
                end
                pending = 1'b0;
            end
            if (req_s && !pending) begin
                if (done_cyc >= 0 || n_words >= 32) begin
                    late_reqs++;
                end else begin
                    a = 3'(n_words % 8);
                    logw[n_words] = word_s;
                    expw[n_words] = (n_words < 8) ? {1'b0, a, 3'b000, mshadow[a]} : {1'b1, a, 12'h000};
                    if (n_words == inj_pos) begin
                        host_we = 1'b1; host_addr = inj_a; host_wdata = inj_d;
                        mshadow[inj_a] = inj_d;
                        if (sel) apply_v = 1'b1; else apply_n = 1'b1;
                    end
                    pending = 1'b1;
                    cnt = (n_words == no_ack_pos) ? 32'h4000_0000 : int'($urandom_range(max_lat, min_lat));
                    to_start = cyc;
                    n_words++;
                end
            end
            if (pending) begin
                if (cnt == 0) begin
                    ack = 1'b1;
                    pending = 1'b0;
                    if (n_words > 8) begin
                        a = 3'((n_words - 1) % 8);
                        rdata = (int'(a) == bad_addr) ? bad_val : mshadow[a];
                    end else begin
                        rdata = 9'($urandom);
                    end
                end else begin
                    cnt--;
                end
            end
        end
        ack = 1'b0;
    endtask

    task automatic test_reset;
        logic [15:0] outs;
        outs = {busy_n, done_n, err_n, erra_n, errto_n, ifn.cfg_req, busy_v, done_v, err_v, erra_v, errto_v, ifv.cfg_req};
        n_tests++;
        if (outs !== 16'h0) begin n_fail++; $display("FAIL reset_outputs got %h exp 0000", outs); end
        n_tests++;
        if ({ifn.cfg_word, ifv.cfg_word} !== 32'h0) begin
            n_fail++; $display("FAIL reset_cfg_word got %h exp 0", {ifn.cfg_word, ifv.cfg_word});
        end
        for (int i = 0; i < 8; i++) begin
            host_addr = 3'(i); #1;
            n_tests++;
            if (hr_n !== 9'h0) begin n_fail++; $display("FAIL reset_shadow[%0d] got %h exp 000", i, hr_n); end
        end
    endtask

    task automatic test_write_only;
        int nw, nd, dc, toc, lr;
        logic [15:0] tbl [8];
        tbl = '{16'h00D8, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h50D8, 16'h6000, 16'h7000};
        sel = 1'b0;
        host_write(3'd0, 9'h0D8);
        host_write(3'd5, 9'h0D8);
        run_seq(20, 20, -1, -1, 9'h0, -1, 3'd0, 9'h0, nw, nd, dc, toc, lr);
        n_tests++;
        if (nw !== 8) begin n_fail++; $display("FAIL wo_nwords got %0d exp 8", nw); end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (logw[i] !== tbl[i]) begin n_fail++; $display("FAIL wo_word[%0d] got %h exp %h", i, logw[i], tbl[i]); end
        end
        n_tests++;
        if (nd !== 1 || lr !== 0) begin n_fail++; $display("FAIL wo_done_once got done=%0d late=%0d exp 1/0", nd, lr); end
        n_tests++;
        if (dc !== 8 * 22 + 1) begin n_fail++; $display("FAIL wo_latency got %0d exp %0d", dc, 8 * 22 + 1); end
        n_tests++;
        if (err_s !== 1'b0) begin n_fail++; $display("FAIL wo_error got %b exp 0", err_s); end
    endtask

    task automatic test_host_rw;
        logic [8:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 9'($urandom);
            host_write(3'(i), v);
        end
        for (int i = 0; i < 8; i++) begin
            host_addr = 3'(i); #1;
            n_tests++;
            if (hr_n !== mshadow[i] || hr_v !== mshadow[i]) begin
                n_fail++; $display("FAIL host_rdata[%0d] got %h/%h exp %h", i, hr_n, hr_v, mshadow[i]);
            end
        end
    endtask

    task automatic test_latency;
        int nw, nd, dc, toc, lr, bad;
        sel = 1'b0;
        run_seq(0, 0, -1, -1, 9'h0, -1, 3'd0, 9'h0, nw, nd, dc, toc, lr);
        bad = 0;
        for (int i = 0; i < 8; i++) if (logw[i] !== expw[i]) bad++;
        n_tests++;
        if (nw !== 8 || bad !== 0) begin n_fail++; $display("FAIL lat_words got n=%0d bad=%0d exp 8/0", nw, bad); end
        n_tests++;
        if (dc !== 17) begin n_fail++; $display("FAIL lat_apply_to_done got %0d exp 17", dc); end
        n_tests++;
        if (busy_s !== 1'b0 || nd !== 1) begin n_fail++; $display("FAIL lat_idle got busy=%b done=%0d exp 0/1", busy_s, nd); end
    endtask

    task automatic test_verify_pass;
        int nw, nd, dc, toc, lr;
        sel = 1'b1;
        run_seq(0, 5, -1, -1, 9'h0, -1, 3'd0, 9'h0, nw, nd, dc, toc, lr);
        n_tests++;
        if (nw !== 16) begin n_fail++; $display("FAIL vp_nwords got %0d exp 16", nw); end
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (logw[i] !== expw[i]) begin n_fail++; $display("FAIL vp_word[%0d] got %h exp %h", i, logw[i], expw[i]); end
        end
        n_tests++;
        if (err_s !== 1'b0 || nd !== 1 || lr !== 0) begin
            n_fail++; $display("FAIL vp_result got err=%b done=%0d late=%0d exp 0/1/0", err_s, nd, lr);
        end
    endtask

    task automatic test_verify_mismatch;
        int nw, nd, dc, toc, lr, bad;
        sel = 1'b1;
        host_write(3'd3, 9'h1AA);
        run_seq(0, 3, -1, 3, 9'h000, -1, 3'd0, 9'h0, nw, nd, dc, toc, lr);
        bad = 0;
        for (int i = 0; i < 16; i++) if (logw[i] !== expw[i]) bad++;
        n_tests++;
        if (nw !== 16 || bad !== 0) begin n_fail++; $display("FAIL vm_words got n=%0d bad=%0d exp 16/0", nw, bad); end
        n_tests++;
        if ({err_s, erra_s, errto_s} !== {1'b1, 3'd3, 1'b0}) begin
            n_fail++; $display("FAIL vm_error got err=%b addr=%0d to=%b exp 1/3/0", err_s, erra_s, errto_s);
        end
        n_tests++;
        if (nd !== 1) begin n_fail++; $display("FAIL vm_done got %0d exp 1", nd); end
    endtask

    task automatic test_timeout;
        int nw, nd, dc, toc, lr;
        sel = 1'b0;
        run_seq(0, 4, 2, -1, 9'h0, -1, 3'd0, 9'h0, nw, nd, dc, toc, lr);
        n_tests++;
        if ({err_s, erra_s, errto_s} !== {1'b1, 3'd2, 1'b1}) begin
            n_fail++; $display("FAIL to_error got err=%b addr=%0d to=%b exp 1/2/1", err_s, erra_s, errto_s);
        end
        n_tests++;
        if (toc !== TO_NV) begin n_fail++; $display("FAIL to_cycles got %0d exp %0d", toc, TO_NV); end
        n_tests++;
        if (nw !== 3 || nd !== 1 || lr !== 0) begin
            n_fail++; $display("FAIL to_seq got n=%0d done=%0d late=%0d exp 3/1/0", nw, nd, lr);
        end
    endtask

    task automatic test_apply_ignored;
        int nw, nd, dc, toc, lr;
        logic [8:0] v;
        sel = 1'b0;
        v = 9'($urandom);
        if (v == mshadow[6]) v = ~v;
        run_seq(1, 4, -1, -1, 9'h0, 2, 3'd6, v, nw, nd, dc, toc, lr);
        n_tests++;
        if (nw !== 8 || nd !== 1 || lr !== 0) begin
            n_fail++; $display("FAIL ai_seq got n=%0d done=%0d late=%0d exp 8/1/0", nw, nd, lr);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (logw[i] !== expw[i]) begin n_fail++; $display("FAIL ai_word[%0d] got %h exp %h", i, logw[i], expw[i]); end
        end
        n_tests++;
        if (logw[6][8:0] !== v) begin n_fail++; $display("FAIL ai_midwrite got %h exp %h", logw[6][8:0], v); end
        n_tests++;
        if (err_s !== 1'b0) begin n_fail++; $display("FAIL ai_error_cleared got %b exp 0", err_s); end
    endtask

    task automatic test_reset_mid;
        int nw, nd, dc, toc, lr, w;
        sel = 1'b0;
        @(posedge clk); #1 apply_n = 1'b1;
        @(posedge clk); #1 apply_n = 1'b0;
        w = 0;
        while (!req_s && w < 50) begin @(posedge clk); #1; w++; end
        n_tests++;
        if (!req_s) begin n_fail++; $display("FAIL rm_req_seen got 0 exp 1"); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({req_s, busy_s, err_s} !== 3'b000) begin
            n_fail++; $display("FAIL rm_async got req=%b busy=%b err=%b exp 000", req_s, busy_s, err_s);
        end
        for (int i = 0; i < 8; i++) mshadow[i] = 9'h0;
        host_addr = 3'd4; #1;
        n_tests++;
        if (hr_n !== 9'h0) begin n_fail++; $display("FAIL rm_shadow got %h exp 000", hr_n); end
        #2 rst_n = 1'b1;
        host_write(3'd0, 9'($urandom));
        run_seq(0, 2, -1, -1, 9'h0, -1, 3'd0, 9'h0, nw, nd, dc, toc, lr);
        n_tests++;
        if (nw !== 8 || logw[0] !== expw[0] || logw[7] !== expw[7]) begin
            n_fail++; $display("FAIL rm_restart got n=%0d w0=%h exp 8/%h", nw, logw[0], expw[0]);
        end
    endtask

    initial begin
        rst_n = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        apply_n = 1'b0; apply_v = 1'b0; sel = 1'b0; ack = 1'b0; rdata = '0;
        for (int i = 0; i < 8; i++) mshadow[i] = 9'h0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        rst_n = 1'b1;
        test_write_only;
        test_host_rw;
        test_latency;
        test_verify_pass;
        test_verify_mismatch;
        test_timeout;
        test_apply_ignored;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ad9826_reg_sequencer.md
Name: ad9826_reg_sequencer

Overview:
- Upstream feeder for the AD9826 serial configuration stage.
- Holds an 8-entry × 9-bit shadow copy of the AD9826 register map, written by the host/USB command decoder.
- On an apply command it writes all eight registers in address order through the serial config stage, then optionally reads each back and compares, reporting pass/fail.
- Sits between the host command decoder and the serial config stage.

Parameters:
- VERIFY, 1: 1 = run the read-back/compare pass after the write pass; 0 = skip it.
- TIMEOUT_CYC, 4096: clk cycles allowed per serial transaction before abort.
- TO_W, 12: width of the timeout counter; must satisfy 2^TO_W ≥ TIMEOUT_CYC.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- host_we  in  1  shadow-register write strobe, one cycle.
- host_addr  in  3  shadow register address.
- host_wdata  in  9  shadow register data.
- host_rdata  out  9  shadow[host_addr], combinational read.
- apply  in  1  start-sequence pulse, one cycle.
- busy  out  1  high while a sequence is running.
- done  out  1  one-cycle pulse when a sequence ends (pass, fail or timeout).
- error  out  1  sticky mismatch/timeout flag; cleared by the next accepted apply.
- err_addr  out  3  address of the first failing register.
- err_timeout  out  1  sticky; 1 = the failure was a timeout, 0 = a compare mismatch.
- cfg_word  out  16  to serial stage: bit15 = R/W (1 = read), bits14:12 = address, bits11:9 = 0, bits8:0 = data.
- cfg_req  out  1  held high until cfg_ack; cfg_word is stable while cfg_req is high.
- cfg_ack  in  1  one-cycle pulse from the serial stage when a transaction completes (sload returns high).
- cfg_rdata  in  9  read data from the serial stage, valid in the cycle cfg_ack is high.

Behaviour:
- Reset values: all outputs 0, shadow = all zeros, FSM in IDLE, addr counter 0.
- Shadow write: host_we writes shadow[host_addr] on the clk edge, in any state.
  - A write during a sequence to an address not yet sent takes effect in that sequence.
  - A write to an address already sent takes effect in the next sequence.
  - A compare always uses the shadow value at CHECK time.
- FSM states: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, FIN.
- IDLE:
  - apply → clear error, err_addr and err_timeout; set addr = 0; go to WR_REQ.
  - apply while busy is ignored.
- WR_REQ: load cfg_word = {0, addr, 000, shadow[addr]}, assert cfg_req, clear the timeout counter → WR_WAIT.
- WR_WAIT:
  - On cfg_ack: drop cfg_req. If addr = 7, go to RD_REQ with addr = 0 when VERIFY = 1, else to FIN. Otherwise addr+1 → WR_REQ.
  - On timeout: error = 1, err_timeout = 1, err_addr = addr, drop cfg_req → FIN.
- RD_REQ: cfg_word = {1, addr, 000, 000000000}, assert cfg_req → RD_WAIT.
- RD_WAIT: on cfg_ack, latch cfg_rdata → CHECK. Timeout is handled as in WR_WAIT.
- CHECK:
  - Mismatch with no earlier error: error = 1, err_addr = addr. The sequence continues; only the first failure is recorded.
  - Then: addr = 7 → FIN; else addr+1 → RD_REQ.
- FIN: done pulse for one cycle, busy = 0 → IDLE.
- Timeout rules:
  - The counter runs only in the WR_WAIT and RD_WAIT states.
  - Timeout fires when the count reaches TIMEOUT_CYC−1 without cfg_ack.
  - If cfg_ack arrives in that same cycle, ack wins.
- cfg_ack outside WR_WAIT or RD_WAIT is ignored.
- Latency:
  - Each register costs 2 clk of overhead plus the serial-stage duration.
  - A write-only sequence with zero-latency ack takes 8×2 + 1 cycles from apply to done.
- Reset mid-sequence: everything returns to reset values immediately and cfg_req drops asynchronously. The downstream stage aborts on its own reset.

Decomposition:
- Shared package ad9826_pkg:
  - Word-field constants: RW_BIT = 15, ADDR_MSB/LSB = 14/12, DATA_MSB/LSB = 8/0.
  - Register address names: CONFIG = 0, MUX = 1, PGA_R/G/B = 2..4, OFFS_R/G/B = 5..7.
  - FSM state encoding.
- One natural sub-module: ad9826_shadow_regs, the 8×9 register file with a write port and two read ports (host and sequencer).

Test Plan:
- Host writes shadow[0] = 0x0D8 and shadow[5] = 0x0D8, VERIFY = 0, apply; bench acks each request 20 cycles later → eight cfg_word values in order: 0x00D8, 0x1000, …, 0x50D8, …, 0x7000. Then one done pulse, error = 0.
- VERIFY = 1, and the bench model echoes the written data → eight reads with cfg_word 0x8000 to 0xF000; done, error = 0.
- VERIFY = 1, and the model returns 0x000 for address 3 (written 0x1AA) → error = 1, err_addr = 3, err_timeout = 0. Reads still continue through address 7.
- Bench never acks address 2 → timeout after TIMEOUT_CYC cycles: error = 1, err_timeout = 1, err_addr = 2, done pulse, no further cfg_req.
- apply pulsed mid-sequence → ignored; host_we to address 6 while the sequencer is at address 2 → the new value appears in the address-6 cfg_word.
- rst_n asserted during WR_WAIT → cfg_req = 0 and busy = 0 immediately. A subsequent apply restarts at address 0.
